// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
//   bcd_t       : one BCD digit
//   sw_state_t  : RUN / PAUSED run-control state
//   BCD_NINE    : largest legal digit value
//   bcd_tens / bcd_ones : split a decimal maximum into its two BCD digits
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } sw_state_t;

  localparam bcd_t BCD_NINE = 4'd9;

  // Tens digit of a two-digit decimal value.
  function automatic bcd_t bcd_tens(input int unsigned v);
    return DIGIT_W'(v / 10);
  endfunction

  // Ones digit of a two-digit decimal value.
  function automatic bcd_t bcd_ones(input int unsigned v);
    return DIGIT_W'(v % 10);
  endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// Two-digit BCD field counter (one MM or SS field) wrapping at MAX.
// Parameters:
//   MAX        largest field value (decimal, <= 99)
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset, clears the field
//   inc_i      advance the field by one
//   clr_i      clear the field to 00
//   tens_o     registered tens digit
//   ones_o     registered ones digit
//   wrap_c     inc_i applied while at MAX (field goes to 00 this cycle)
//   is_max_c   field currently equals MAX
module bcd_field_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       wrap_c,
  output logic       is_max_c
);

  localparam bcd_t MAX_TENS = bcd_tens(MAX);
  localparam bcd_t MAX_ONES = bcd_ones(MAX);

  bcd_t tens_q, tens_d;
  bcd_t ones_q, ones_d;

  assign is_max_c = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
  assign wrap_c   = inc_i && is_max_c;

  // Next-state BCD increment; ones roll 9->0 and carry into tens.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr_i) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc_i) begin
      if (is_max_c) begin
        tens_d = '0;
        ones_d = '0;
      end else if (ones_q == BCD_NINE) begin
        tens_d = tens_q + DIGIT_W'(1);
        ones_d = '0;
      end else begin
        ones_d = ones_q + DIGIT_W'(1);
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch driven by single-cycle tick enables from the clock divider.
// Run mode counts seconds on tick_1hz; adjust mode (adj=1) bumps the field chosen
// by sel on tick_2hz without carry. pause_pulse toggles RUN/PAUSED in any mode.
// Build option: STOPWATCH_ROLLOVER_EN -- when defined the count rolls from
// MIN_MAX:SEC_MAX to 00:00; otherwise it saturates there (adjust still works).
// Ports:
//   clk_master   clock
//   rst          synchronous active-high reset
//   tick_1hz     1 Hz count enable
//   tick_2hz     2 Hz adjust enable
//   pause_pulse  toggles run/pause
//   adj          1 = adjust mode
//   sel          adjust target: 0 = minutes, 1 = seconds
//   min_tens/min_ones/sec_tens/sec_ones  registered BCD digits
//   running      1 in RUN state
//   at_max       count equals MIN_MAX:SEC_MAX (decoded from registered digits)
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_MAX = 59,
  parameter int unsigned SEC_MAX = 59
) (
  input  logic       clk_master,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       at_max
);

  sw_state_t state_q, state_d;

  logic count_c;
  logic sec_inc_c;
  logic min_inc_c;
  logic sec_wrap_c;
  logic min_wrap_c;
  logic sec_max_c;
  logic min_max_c;
  logic count_ok_c;

  assign at_max = sec_max_c && min_max_c;

`ifdef STOPWATCH_ROLLOVER_EN
  assign count_ok_c = 1'b1;
`else
  assign count_ok_c = !at_max;
`endif

  // Run-state register.
  always_ff @(posedge clk_master) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and field increment muxing. The tick uses the current state,
  // so a pause_pulse coinciding with a count tick still lets the tick land.
  always_comb begin
    state_d   = state_q;
    count_c   = 1'b0;
    sec_inc_c = 1'b0;
    min_inc_c = 1'b0;

    if (pause_pulse) begin
      state_d = (state_q == RUN) ? PAUSED : RUN;
    end

    if (adj) begin
      if (tick_2hz) begin
        sec_inc_c = sel;
        min_inc_c = !sel;
      end
    end else if ((state_q == RUN) && tick_1hz && count_ok_c) begin
      count_c   = 1'b1;
      sec_inc_c = 1'b1;
      // Only counting carries seconds into minutes; adjust never does.
      min_inc_c = sec_max_c;
    end
  end

  bcd_field_counter #(
    .MAX (SEC_MAX)
  ) u_sec (
    .clk_i    (clk_master),
    .rst_i    (rst),
    .inc_i    (sec_inc_c),
    .clr_i    (1'b0),
    .tens_o   (sec_tens),
    .ones_o   (sec_ones),
    .wrap_c   (sec_wrap_c),
    .is_max_c (sec_max_c)
  );

  bcd_field_counter #(
    .MAX (MIN_MAX)
  ) u_min (
    .clk_i    (clk_master),
    .rst_i    (rst),
    .inc_i    (min_inc_c),
    .clr_i    (1'b0),
    .tens_o   (min_tens),
    .ones_o   (min_ones),
    .wrap_c   (min_wrap_c),
    .is_max_c (min_max_c)
  );

  assign running = (state_q == RUN);

  // Wrap strobes are informational at this level.
  logic unused_c;
  assign unused_c = sec_wrap_c ^ min_wrap_c ^ count_c;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: each step drives one clock of inputs,
// a decimal reference model pushes the expected outputs to a queue, and the
// value is popped and compared one step after the active edge.
module tb_stopwatch_counter;

  logic       clk_master;
  logic       rst;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       pause_pulse;
  logic       adj;
  logic       sel;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       at_max;

  stopwatch_counter dut (
    .clk_master  (clk_master),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .tick_2hz    (tick_2hz),
    .pause_pulse (pause_pulse),
    .adj         (adj),
    .sel         (sel),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .running     (running),
    .at_max      (at_max)
  );

  initial begin
    clk_master = 1'b0;
    forever #5 clk_master = ~clk_master;
  end

  typedef struct {
    string       tag;
    logic [17:0] val;
  } exp_t;

  exp_t exp_q[$];

  int vectors;
  int miscompares;

  // Reference model state, plain decimal.
  int m_min;
  int m_sec;
  bit m_run;

  function automatic logic [17:0] pack_exp(input int mm, input int ss, input bit run);
    logic [17:0] v;
    v[17:14] = 4'(mm / 10);
    v[13:10] = 4'(mm % 10);
    v[9:6]   = 4'(ss / 10);
    v[5:2]   = 4'(ss % 10);
    v[1]     = run;
    v[0]     = (mm == 59) && (ss == 59);
    return v;
  endfunction

  // One clock of stimulus: model update + push, then edge, then pop + compare.
  task automatic step(input bit r, input bit t1, input bit t2, input bit pp,
                      input bit a, input bit s, input string tag);
    exp_t        e;
    logic [17:0] obs;
    @(negedge clk_master);
    rst         = r;
    tick_1hz    = t1;
    tick_2hz    = t2;
    pause_pulse = pp;
    adj         = a;
    sel         = s;
    if (r) begin
      m_min = 0;
      m_sec = 0;
      m_run = 1'b1;
    end else begin
      if (!a && m_run && t1) begin
        if (m_min == 59 && m_sec == 59) begin
`ifdef STOPWATCH_ROLLOVER_EN
          m_min = 0;
          m_sec = 0;
`endif
        end else if (m_sec == 59) begin
          m_sec = 0;
          m_min = m_min + 1;
        end else begin
          m_sec = m_sec + 1;
        end
      end else if (a && t2) begin
        if (s) m_sec = (m_sec == 59) ? 0 : m_sec + 1;
        else   m_min = (m_min == 59) ? 0 : m_min + 1;
      end
      if (pp) m_run = !m_run;
    end
    e.tag = tag;
    e.val = pack_exp(m_min, m_sec, m_run);
    exp_q.push_back(e);
    @(posedge clk_master);
    #1;
    e   = exp_q.pop_front();
    obs = {min_tens, min_ones, sec_tens, sec_ones, running, at_max};
    vectors++;
    assert (obs === e.val) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (mmss/run/max)", e.tag, obs, e.val);
    end
  endtask

  task automatic repeat_step(input int n, input bit t1, input bit t2, input bit a,
                             input bit s, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, t1, t2, 1'b0, a, s, tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_min = 0;
    m_sec = 0;
    m_run = 1'b1;
    rst = 1'b1; tick_1hz = 1'b0; tick_2hz = 1'b0;
    pause_pulse = 1'b0; adj = 1'b0; sel = 1'b0;

    // 1. Reset then five counting ticks.
    step(1, 0, 0, 0, 0, 0, "reset");
    step(0, 0, 0, 0, 0, 0, "idle_after_reset");
    repeat_step(5, 1, 0, 0, 0, "count_5");
    step(0, 0, 1, 0, 0, 0, "tick2_ignored_run");

    // 2. Preload 00:59 by adjusting seconds, then carry into minutes.
    repeat_step(54, 0, 1, 1, 1, "adj_sec_to_59");
    step(0, 1, 0, 0, 0, 0, "carry_01_00");
    // Preload 59:59 and hit the limit.
    repeat_step(58, 0, 1, 1, 0, "adj_min_to_59");
    repeat_step(59, 0, 1, 1, 1, "adj_sec_to_59b");
    step(0, 0, 0, 0, 0, 0, "at_max_idle");
    step(0, 1, 0, 0, 0, 0, "tick_at_max");
    step(0, 1, 0, 0, 0, 0, "tick_after_max");
    // Adjust at the limit wraps seconds with no minute carry.
    step(1, 0, 0, 0, 0, 0, "reset2");
    repeat_step(59, 0, 1, 1, 0, "adj_min_59");
    repeat_step(59, 0, 1, 1, 1, "adj_sec_59");
    step(0, 0, 1, 0, 1, 1, "adj_sec_wrap_nocarry");
    step(0, 0, 1, 0, 1, 0, "adj_min_wrap");

    // 3. Pause holds the count through ticks, resume counts again.
    step(0, 0, 0, 1, 0, 0, "pause");
    repeat_step(10, 1, 0, 0, 0, "paused_ticks");
    step(0, 0, 0, 1, 0, 0, "resume");
    step(0, 1, 0, 0, 0, 0, "count_after_resume");

    // 4. From 00:58 adjust seconds with wrap, then minutes.
    step(1, 0, 0, 0, 0, 0, "reset3");
    repeat_step(58, 0, 1, 1, 1, "adj_sec_58");
    repeat_step(3, 0, 1, 1, 1, "adj_sec_wrap3");
    repeat_step(2, 0, 1, 1, 0, "adj_min_2");
    step(0, 1, 0, 0, 1, 1, "adj_ignores_1hz");

    // 5. Both ticks in adjust: only tick_2hz acts; both in run: only tick_1hz.
    step(0, 1, 1, 0, 1, 0, "adj_both_ticks");
    step(0, 1, 1, 0, 0, 0, "run_both_ticks");
    // Pause toggles in adjust mode; leaving adjust keeps PAUSED and the count.
    step(0, 0, 0, 1, 1, 0, "pause_in_adj");
    step(0, 1, 0, 0, 0, 0, "leave_adj_paused");
    step(0, 0, 1, 0, 1, 1, "adj_while_paused");
    step(0, 0, 0, 1, 0, 0, "resume2");
    // Tick and pause together: tick lands, then state toggles.
    step(0, 1, 0, 1, 0, 0, "tick_with_pause");
    step(0, 1, 0, 0, 0, 0, "tick_after_pause");

    // 6. Reset beats tick and pause at 12:34.
    step(1, 0, 0, 0, 0, 0, "reset4");
    repeat_step(12, 0, 1, 1, 0, "adj_min_12");
    repeat_step(34, 0, 1, 1, 1, "adj_sec_34");
    step(0, 0, 0, 1, 0, 0, "pause_at_1234");
    step(1, 1, 0, 1, 0, 0, "reset_wins");
    step(0, 1, 0, 0, 0, 0, "count_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
